// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store alignment unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DATA   = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] WMASK_NONE = 4'b0000;
  localparam logic [3:0] WMASK_B    = 4'b0001;
  localparam logic [3:0] WMASK_H    = 4'b0011;
  localparam logic [3:0] WMASK_W    = 4'b1111;

endpackage

// File: rtl/lsu_align_if.sv
// Request/response handshake plus data-RAM port of the LSU.
interface lsu_align_if #(parameter int ADDR_W = 32);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // slave = the LSU; master = core plus RAM around it
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wmask, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wmask, mem_wdata
  );

endinterface

// File: rtl/lsu_fmt.sv
// Combinational formatting: store mask/lane replication/error check and
// load byte-lane extraction with sign/zero extension.
module lsu_fmt
  import lsu_pkg::*;
(
  input  logic        st_we,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  output logic [31:0] st_wdata_rep,
  output logic        st_err,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    st_wmask     = WMASK_NONE;
    st_wdata_rep = st_wdata;
    st_err       = 1'b0;
    case (st_funct3)
      F3_B, F3_BU: begin
        st_wmask     = WMASK_B << st_off;
        st_wdata_rep = {4{st_wdata[7:0]}};
        st_err       = st_we & st_funct3[2];
      end
      F3_H, F3_HU: begin
        st_wmask     = WMASK_H << {st_off[1], 1'b0};
        st_wdata_rep = {2{st_wdata[15:0]}};
        st_err       = st_off[0] | (st_we & st_funct3[2]);
      end
      F3_W: begin
        st_wmask = WMASK_W;
        st_err   = (st_off != 2'b00);
      end
      default: st_err = 1'b1;
    endcase
    // loads never write, and an erroring request never touches the RAM
    if (!st_we || st_err) st_wmask = WMASK_NONE;
  end

  always_comb begin
    shifted = ld_rdata >> {ld_off, 3'b000};
    case (ld_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   ld_data = {24'h0, shifted[7:0]};
      F3_HU:   ld_data = {16'h0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// LSU sequencing FSM and output registers; formatting lives in lsu_fmt.
//   state  | meaning
//   IDLE   | req_ready=1, accept and decode a request
//   ACCESS | RAM sampled at closing edge; store mask active
//   DATA   | RAM read data valid, captured into rsp_rdata
//   RESP   | rsp_valid held until rsp_ready
module lsu_align
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic        clk,
  input logic        resetn,
  lsu_align_if.slave bus
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic [3:0]        st_wmask;
  logic [31:0]       st_wdata_rep;
  logic              st_err;
  logic [31:0]       ld_data;

  lsu_fmt u_fmt (
    .st_we        (bus.req_we),
    .st_funct3    (bus.req_funct3),
    .st_off       (bus.req_addr[1:0]),
    .st_wdata     (bus.req_wdata),
    .st_wmask     (st_wmask),
    .st_wdata_rep (st_wdata_rep),
    .st_err       (st_err),
    .ld_funct3    (funct3_q),
    .ld_off       (off_q),
    .ld_rdata     (bus.mem_rdata),
    .ld_data      (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = WMASK_NONE;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d        = bus.req_we;
          funct3_d    = bus.req_funct3;
          off_d       = bus.req_addr[1:0];
          mem_addr_d  = bus.req_addr;
          mem_wdata_d = st_wdata_rep;
          rsp_rdata_d = '0;
          rsp_err_d   = st_err;
          if (st_err) begin
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            mem_wmask_d = st_wmask;
            state_d     = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          state_d = DATA;
        end
      end
      DATA: begin
        rsp_rdata_d = ld_data;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= WMASK_NONE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a registered-read RAM model.
module tb_lsu_align;

  logic clk;
  logic resetn;
  int   n_vec;
  int   n_err;

  lsu_align_if #(.ADDR_W(32)) bus ();

  lsu_align #(.ADDR_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [0:16383];
  logic [31:0] ram_rdata;
  logic [13:0] ram_idx;

  assign ram_idx       = bus.mem_addr[15:2];
  assign bus.mem_rdata = ram_rdata;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.mem_wmask[b]) ram[ram_idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    ram_rdata <= ram[ram_idx];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, follow it to its response, then release it after 'hold' stall cycles.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output int lat, output logic [31:0] rd, output logic er,
                        output logic [3:0] wm, output logic [31:0] wd, output logic [31:0] ma);
    logic [31:0] rd0;
    chk({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wm  = 4'b0000;
    wd  = 32'h0;
    ma  = bus.mem_addr;
    lat = 1;
    while (!bus.rsp_valid && lat < 8) begin
      if (bus.mem_wmask != 4'b0000) begin
        wm = bus.mem_wmask;
        wd = bus.mem_wdata;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (bus.mem_wmask != 4'b0000) wm = bus.mem_wmask;
    rd  = bus.rsp_rdata;
    er  = bus.rsp_err;
    rd0 = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
      chk({tag, "_stall_rdata"}, bus.rsp_rdata, rd0);
      chk({tag, "_stall_ready"}, {31'b0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, {31'b0, bus.rsp_valid}, 32'd0);
  endtask

  task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] exp_wm,
                       input logic [31:0] exp_wd);
    int lat; logic [31:0] rd, wd, ma; logic er; logic [3:0] wm;
    do_req(tag, 1'b1, f3, addr, wdata, 0, lat, rd, er, wm, wd, ma);
    chk({tag, "_lat"}, lat, 32'd2);
    chk({tag, "_err"}, {31'b0, er}, 32'd0);
    chk({tag, "_wmask"}, {28'b0, wm}, {28'b0, exp_wm});
    chk({tag, "_wdata"}, wd, exp_wd);
    chk({tag, "_addr"}, ma, addr);
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                      input int hold, input logic [31:0] exp_rd);
    int lat; logic [31:0] rd, wd, ma; logic er; logic [3:0] wm;
    do_req(tag, 1'b0, f3, addr, 32'h0, hold, lat, rd, er, wm, wd, ma);
    chk({tag, "_lat"}, lat, 32'd3);
    chk({tag, "_err"}, {31'b0, er}, 32'd0);
    chk({tag, "_wmask"}, {28'b0, wm}, 32'd0);
    chk({tag, "_rdata"}, rd, exp_rd);
  endtask

  task automatic bad(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr);
    int lat; logic [31:0] rd, wd, ma; logic er; logic [3:0] wm;
    do_req(tag, we, f3, addr, 32'hFFFF_FFFF, 0, lat, rd, er, wm, wd, ma);
    chk({tag, "_lat"}, lat, 32'd1);
    chk({tag, "_err"}, {31'b0, er}, 32'd1);
    chk({tag, "_rdata"}, rd, 32'd0);
    chk({tag, "_wmask"}, {28'b0, wm}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 16384; i++) ram[i] <= 32'h0;
    resetn         = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b0;
    #3;
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'b0, bus.rsp_err},   32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_mem_addr",  bus.mem_addr,  32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_wmask", {28'b0, bus.mem_wmask}, 32'd0);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    #20 resetn = 1'b1;
    @(posedge clk); #1;

    store("sw104", 3'b010, 32'h104, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    store("sb103", 3'b000, 32'h103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    load ("lb103",  3'b000, 32'h103, 0, 32'hFFFF_FFA5);
    load ("lbu103", 3'b100, 32'h103, 0, 32'h0000_00A5);
    store("sw200", 3'b010, 32'h200, 32'h8001_7FFF, 4'b1111, 32'h8001_7FFF);
    load ("lh202",  3'b001, 32'h202, 0, 32'hFFFF_8001);
    load ("lhu200", 3'b101, 32'h200, 0, 32'h0000_7FFF);
    load ("lw104",  3'b010, 32'h104, 0, 32'hDEAD_BEEF);
    load ("lb105",  3'b000, 32'h105, 0, 32'hFFFF_FFBE);
    load ("lhu106", 3'b101, 32'h106, 0, 32'h0000_DEAD);
    store("sh106", 3'b001, 32'h106, 32'h0000_1234, 4'b1100, 32'h1234_1234);
    load ("lw104b", 3'b010, 32'h104, 0, 32'h1234_BEEF);

    bad("lw102",  1'b0, 3'b010, 32'h102);
    bad("sh101",  1'b1, 3'b001, 32'h101);
    bad("ld011",  1'b0, 3'b011, 32'h100);
    bad("sbu100", 1'b1, 3'b100, 32'h100);
    bad("lh_odd", 1'b0, 3'b001, 32'h203);
    load("lw100_after_err", 3'b010, 32'h100, 0, 32'hA500_0000);

    load("lw200_stall", 3'b010, 32'h200, 5, 32'h8001_7FFF);
    chk("stall_release_idle", {31'b0, bus.req_ready}, 32'd1);

    store("sw300", 3'b010, 32'h300, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h300;
    bus.req_wdata  = 32'h1234_5678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rstmid_access_wmask", {28'b0, bus.mem_wmask}, 32'hF);
    #2 resetn = 1'b0;
    #1;
    chk("rstmid_wmask",     {28'b0, bus.mem_wmask}, 32'd0);
    chk("rstmid_mem_addr",  bus.mem_addr,  32'd0);
    chk("rstmid_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rstmid_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    @(posedge clk); #3;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_rsp_after", {31'b0, bus.rsp_valid}, 32'd0);
    load("lw300_old", 3'b010, 32'h300, 0, 32'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
